mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single memory interface.
// Each port owns one request slot. A one-cycle mX_req pulse is captured only
// while the slot is empty. The FSM takes one pending slot at a time, drives
// it onto the mem_* bus for the whole ISSUE state, and reports completion on
// mX_ack. If mem_busy stays high for TIMEOUT cycles, the request ends with
// mX_err set.
//
// Parameters
//   TIMEOUT  busy cycles tolerated in ISSUE before abort (1..255)
//   FAIR     1 = round-robin on ties, 0 = m0 always wins ties
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   mX_req/we/addr/wdata/
//   mX_size/signed             request pulse and its attributes
//   mX_pend                    slot occupied (new requests are ignored)
//   mX_ack, mX_err, mX_rdata   completion pulse, timeout flag, read data
//   mem_*                      memory-side request and response
//
// state | meaning
// IDLE  | no transaction in flight; choose a pending slot
// ISSUE | mem_re or mem_we asserted; wait for !mem_busy or timeout
// DONE  | ack/err pulse for the granted port; free its slot
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          FAIR    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  input  logic        m0_signed,
  output logic        m0_pend,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  input  logic        m1_signed,
  output logic        m1_pend,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_re,
  output logic        mem_we,
  output logic        mem_signed,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;

  logic        s0_we, s1_we;
  logic [31:0] s0_addr, s1_addr;
  logic [31:0] s0_wdata, s1_wdata;
  logic [1:0]  s0_size, s1_size;
  logic        s0_signed, s1_signed;

  logic        grant_q;   // port currently in flight (0 = m0)
  logic        last_q;    // port granted most recently
  logic        cur_we;
  logic [7:0]  cnt_q;
  logic        err_q;

  logic        sel;
  logic        start;
  logic        finish_ok;
  logic        finish_to;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    sel       = 1'b0;
    start     = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_pend || m1_pend) begin
          start   = 1'b1;
          state_d = ISSUE;
          if (m0_pend && m1_pend) sel = FAIR ? ~last_q : 1'b0;
          else                    sel = m1_pend;
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          finish_ok = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          finish_to = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request slots. A granted slot is still pending during DONE, so a request
  // arriving with its own ack is dropped and the set/clear never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_pend   <= 1'b0;
      s0_we     <= 1'b0;
      s0_addr   <= '0;
      s0_wdata  <= '0;
      s0_size   <= '0;
      s0_signed <= 1'b0;
    end else if (m0_req && !m0_pend) begin
      m0_pend   <= 1'b1;
      s0_we     <= m0_we;
      s0_addr   <= m0_addr;
      s0_wdata  <= m0_wdata;
      s0_size   <= m0_size;
      s0_signed <= m0_signed;
    end else if (state_q == DONE && !grant_q) begin
      m0_pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_pend   <= 1'b0;
      s1_we     <= 1'b0;
      s1_addr   <= '0;
      s1_wdata  <= '0;
      s1_size   <= '0;
      s1_signed <= 1'b0;
    end else if (m1_req && !m1_pend) begin
      m1_pend   <= 1'b1;
      s1_we     <= m1_we;
      s1_addr   <= m1_addr;
      s1_wdata  <= m1_wdata;
      s1_size   <= m1_size;
      s1_signed <= m1_signed;
    end else if (state_q == DONE && grant_q) begin
      m1_pend   <= 1'b0;
    end
  end

  // The memory bus is loaded once when leaving IDLE, so it stays constant
  // throughout ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q        <= 1'b0;
      last_q         <= 1'b0;
      cur_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_size       <= '0;
      mem_signed     <= 1'b0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
    end else begin
      if (start) begin
        grant_q        <= sel;
        cur_we         <= sel ? s1_we     : s0_we;
        mem_addr       <= sel ? s1_addr   : s0_addr;
        mem_write_data <= sel ? s1_wdata  : s0_wdata;
        mem_size       <= sel ? s1_size   : s0_size;
        mem_signed     <= sel ? s1_signed : s0_signed;
        cnt_q          <= '0;
      end else if (state_q == ISSUE && mem_busy) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (finish_ok) begin
        err_q <= 1'b0;
        if (!cur_we) begin
          if (grant_q) m1_rdata <= mem_read_data;
          else         m0_rdata <= mem_read_data;
        end
      end else if (finish_to) begin
        err_q <= 1'b1;
      end
      if (state_q == DONE) last_q <= grant_q;
    end
  end

  assign mem_re = (state_q == ISSUE) && !cur_we;
  assign mem_we = (state_q == ISSUE) &&  cur_we;
  assign m0_ack = (state_q == DONE) && !grant_q;
  assign m1_ack = (state_q == DONE) &&  grant_q;
  assign m0_err = m0_ack && err_q;
  assign m1_err = m1_ack && err_q;

endmodule
